seg_scanner: RTL and testbench
==============================

# seg_scanner

Time-multiplexed driver for the eight-digit common-anode seven-segment display on the ALU board. It owns the digit-select index `rr`, presents it to the ALU display decoder, and converts the returned 5-bit `digit_holder` code into registered segment and anode drive. Anode drive is blanked at every digit change to prevent ghosting. It sits between the ALU decoder and the board's `CA..CG`, `DP` and `AN` pins.

## Interface
Parameters:
- `REFRESH_DIV`, 100000: clock cycles per digit slot; 1 kHz per digit, 125 Hz per frame at 100 MHz. Legal range is 4 to 2^20.
- `BLANK_CYCLES`, 1000: cycles at the start of each slot during which all anodes are off. Legal range is 1 to `REFRESH_DIV`-2.

Ports:
- `CLK100MHZ`  in  1  system clock, single clock domain.
- `CPU_RESETN`  in  1  asynchronous, active-low reset.
- `digit_holder`  in  5  display code for the digit selected by `rr`, combinational from `rr`.
- `rr`  out  3  current digit index; 0 = rightmost … 7 = leftmost. Registered.
- `AN`  out  8  anode enables, active low. Registered.
- `SEG`  out  7  `{CG,CF,CE,CD,CC,CB,CA}`, active low. Registered.
- `DP`  out  1  decimal point, active low. Always 1.
- `frame_tick`  out  1  one-cycle pulse when `rr` wraps from 7 to 0.

## Operation
- Slot counter `div_cnt` runs from 0 to `REFRESH_DIV`-1.
- When `div_cnt` = `REFRESH_DIV`-1:
  - `div_cnt` returns to 0.
  - `rr` increments, wrapping 7→0.
  - `frame_tick` is 1 in the cycle `rr` becomes 0; it is 0 at all other times.
- `SEG` is registered every cycle from `seg_decode(digit_holder)`:
  - codes 0–15: hex glyphs 0–F.
  - code 16: blank, 7'h7F.
  - code 17: minus, 7'h3F, segment G only.
  - codes 18–31: blank.
- Glyph values:
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30
  - 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78
  - 8 = 7'h00, 9 = 7'h10, A = 7'h08, b = 7'h03
  - C = 7'h46, d = 7'h21, E = 7'h06, F = 7'h0E
- `AN` is registered:
  - All ones while `div_cnt` < `BLANK_CYCLES`.
  - Otherwise `~(8'b1 << rr)`: exactly one zero.
- Reset values:
  - `rr` = 0, `div_cnt` = 0.
  - `AN` = 8'hFF, `SEG` = 7'h7F, `DP` = 1, `frame_tick` = 0.
- Reset asserted mid-slot: all outputs return to their reset values immediately (asynchronous). After release, scanning restarts at digit 0, slot cycle 0.
- Changes on `digit_holder` mid-slot, e.g. operand switches or the `DispCont` toggle, appear on `SEG` one cycle later. No extra latching.

## Timing
- Edge at which `div_cnt` wraps to 0:
  - `rr` takes its new value.
  - `AN` becomes 8'hFF at the same edge, so the old digit is never lit with the new code.
- One cycle later, `SEG` reflects `digit_holder` for the new `rr`. `BLANK_CYCLES` ≥ 1 guarantees `SEG` is settled before any anode asserts.
- First anode-low edge in a slot: the edge at which `div_cnt` becomes `BLANK_CYCLES`.
- Lit time per slot: `REFRESH_DIV` - `BLANK_CYCLES` cycles.
- Full frame: 8 × `REFRESH_DIV` cycles. `frame_tick` period equals one frame.
- Outputs are glitch-free: all are flop outputs.

## Structure
- Package `seg_pkg` holds:
  - `CODE_BLANK` = 5'd16 and `CODE_MINUS` = 5'd17; the ALU decoder imports the same constants.
  - The 16 glyph constants, `SEG_BLANK` and `SEG_MINUS`.
- Sub-module `seg_decode`: purely combinational, 5-bit code to 7-bit active-low pattern.
- Top level `seg_scanner` holds:
  - the `div_cnt` counter, sized `$clog2(REFRESH_DIV)`.
  - `rr`, the `AN`/`SEG` output registers, and `frame_tick`.

## Test plan
All scenarios use `REFRESH_DIV`=8 and `BLANK_CYCLES`=2.
- **Reset:** hold `CPU_RESETN` low, toggle the clock. Expect `AN`=8'hFF, `SEG`=7'h7F, `DP`=1, `rr`=0, `frame_tick`=0. After release, `AN`=8'hFE first at cycle 2.
- **Scan order:** a model drives `digit_holder` = `rr`. Expect:
  - `rr` sequence 0,1,…,7,0 with a change every 8 cycles.
  - `AN` low bit walks FE→FD→…→7F.
  - `SEG` = glyph(rr) whenever any anode is low.
  - `frame_tick` high once per 64 cycles, coincident with `rr`=0.
- **Special codes:** drive 16, 17, 31 and 10. Expect `SEG` = 7'h7F, 7'h3F, 7'h7F and 7'h08 respectively, each one cycle after the code is applied.
- **Anti-ghost:** `digit_holder` = 8 on `rr`=3 and 16 otherwise. Expect `AN[3]` low only while `rr`=3 with `SEG`=7'h00. No cycle has `AN[4]` low while `SEG`=7'h00.
- **Mid-slot reset:** assert `CPU_RESETN` at `rr`=5, `div_cnt`=4. Expect outputs at reset values in the same cycle. After release, `rr` restarts at 0 with a full 8-cycle slot.
- **Mid-slot code change:** `digit_holder` changes 3→17 at slot cycle 5. Expect `SEG` to change 7'h30→7'h3F one cycle later while `AN` stays low.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared display codes and active-low seven-segment patterns.
// Segment bit order is {G,F,E,D,C,B,A}; a 0 lights the segment.
`timescale 1ns/1ps
package seg_pkg;

  // Non-hex display codes, also used by the ALU display decoder
  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_MINUS = 5'd17;

  localparam logic [6:0] SEG_GLYPH_0 = 7'h40;
  localparam logic [6:0] SEG_GLYPH_1 = 7'h79;
  localparam logic [6:0] SEG_GLYPH_2 = 7'h24;
  localparam logic [6:0] SEG_GLYPH_3 = 7'h30;
  localparam logic [6:0] SEG_GLYPH_4 = 7'h19;
  localparam logic [6:0] SEG_GLYPH_5 = 7'h12;
  localparam logic [6:0] SEG_GLYPH_6 = 7'h02;
  localparam logic [6:0] SEG_GLYPH_7 = 7'h78;
  localparam logic [6:0] SEG_GLYPH_8 = 7'h00;
  localparam logic [6:0] SEG_GLYPH_9 = 7'h10;
  localparam logic [6:0] SEG_GLYPH_A = 7'h08;
  localparam logic [6:0] SEG_GLYPH_B = 7'h03;
  localparam logic [6:0] SEG_GLYPH_C = 7'h46;
  localparam logic [6:0] SEG_GLYPH_D = 7'h21;
  localparam logic [6:0] SEG_GLYPH_E = 7'h06;
  localparam logic [6:0] SEG_GLYPH_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Hex nibble to glyph pattern
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] pat;
    pat = SEG_BLANK;
    case (nib)
      4'h0: pat = SEG_GLYPH_0;
      4'h1: pat = SEG_GLYPH_1;
      4'h2: pat = SEG_GLYPH_2;
      4'h3: pat = SEG_GLYPH_3;
      4'h4: pat = SEG_GLYPH_4;
      4'h5: pat = SEG_GLYPH_5;
      4'h6: pat = SEG_GLYPH_6;
      4'h7: pat = SEG_GLYPH_7;
      4'h8: pat = SEG_GLYPH_8;
      4'h9: pat = SEG_GLYPH_9;
      4'hA: pat = SEG_GLYPH_A;
      4'hB: pat = SEG_GLYPH_B;
      4'hC: pat = SEG_GLYPH_C;
      4'hD: pat = SEG_GLYPH_D;
      4'hE: pat = SEG_GLYPH_E;
      4'hF: pat = SEG_GLYPH_F;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational 5-bit display code to active-low segment pattern.
// Codes 0-15 are hex glyphs, 17 is a minus sign, everything else is blank.
`timescale 1ns/1ps
module seg_decode
  import seg_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg
);

  // Hex range is selected by the top code bit being clear
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_code[4]) begin
      o_seg = hex_glyph(i_code[3:0]);
    end else if (i_code == CODE_MINUS) begin
      o_seg = SEG_MINUS;
    end
  end

endmodule

// File: rtl/seg_scanner.sv
// Eight-digit time-multiplexed seven-segment scanner.
// Owns the digit index rr, registers the decoded segments each cycle and
// blanks all anodes for the first BLANK_CYCLES of every digit slot so the
// previous digit never shows the new digit's segments.
`timescale 1ns/1ps
module seg_scanner
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [4:0] digit_holder,
  output logic [2:0] rr,
  output logic [7:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       frame_tick
);

  localparam int               CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] w_div_cnt_next;
  logic [2:0]       r_rr;
  logic [2:0]       w_rr_next;
  logic             w_slot_end;
  logic [7:0]       w_digit_sel;
  logic [7:0]       w_an_next;
  logic [7:0]       r_an;
  logic [6:0]       w_seg_dec;
  logic [6:0]       r_seg;
  logic             r_frame_tick;

  seg_decode u_decode (
    .i_code (digit_holder),
    .o_seg  (w_seg_dec)
  );

  // Slot counter and digit index advance; anode drive is derived from the
  // values being loaded so blanking starts on the very edge rr changes
  always_comb begin
    w_slot_end     = (r_div_cnt == CNT_LAST);
    w_div_cnt_next = w_slot_end ? '0 : r_div_cnt + CNT_W'(1);
    w_rr_next      = w_slot_end ? r_rr + 3'd1 : r_rr;
    w_an_next      = (w_div_cnt_next < BLANK_END) ? 8'hFF : ~w_digit_sel;
  end

  // One-hot select of the upcoming digit
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit_sel
      assign w_digit_sel[gi] = (w_rr_next == 3'(gi));
    end
  endgenerate

  // Output and scan-state registers
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_div_cnt    <= '0;
      r_rr         <= 3'd0;
      r_an         <= 8'hFF;
      r_seg        <= SEG_BLANK;
      r_frame_tick <= 1'b0;
    end else begin
      r_div_cnt    <= w_div_cnt_next;
      r_rr         <= w_rr_next;
      r_an         <= w_an_next;
      r_seg        <= w_seg_dec;
      r_frame_tick <= w_slot_end && (r_rr == 3'd7);
    end
  end

  assign rr         = r_rr;
  assign AN         = r_an;
  assign SEG        = r_seg;
  assign DP         = 1'b1;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scanner.sv
// Scoreboard bench for seg_scanner with REFRESH_DIV=8, BLANK_CYCLES=2.
// A reference model counts clock edges since reset release and derives the
// expected outputs arithmetically; a monitor pops and compares each cycle.
`timescale 1ns/1ps
module tb_seg_scanner;

  localparam int RD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] dh;
  logic [2:0] rr;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       ft;

  int checks = 0;
  int errors = 0;

  // Stimulus: a per-digit code table plus an override for mid-slot changes
  logic [4:0] codes [8];
  logic       ovr_en  = 1'b0;
  logic [4:0] ovr_val = 5'd0;

  // Edges since reset release, maintained by the model
  int k = 0;

  typedef struct packed {
    logic [2:0] rr;
    logic [7:0] an;
    logic [6:0] seg;
    logic       ft;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  // Behaves like the ALU decoder: code is a function of the current rr
  assign dh = ovr_en ? ovr_val : codes[rr];

  seg_scanner #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .CLK100MHZ    (clk),
    .CPU_RESETN   (rst_n),
    .digit_holder (dh),
    .rr           (rr),
    .AN           (an),
    .SEG          (seg),
    .DP           (dp),
    .frame_tick   (ft)
  );

  function automatic logic [6:0] ref_glyph(input logic [4:0] code);
    logic [6:0] hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    if (code < 5'd16) return hex[code[3:0]];
    if (code == 5'd17) return 7'h3F;
    return 7'h7F;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d t=%0t", name, act, exp, k, $time);
    end
  endtask

  // Reference model: expected state after each edge from the edge count
  always @(posedge clk) begin : model
    int         kn;
    logic [4:0] dh_exp;
    exp_t       e;
    if (!rst_n) begin
      k <= 0;
    end else begin
      dh_exp = ovr_en ? ovr_val : codes[(k / RD) % 8];
      kn     = k + 1;
      e.rr   = 3'((kn / RD) % 8);
      e.an   = ((kn % RD) < BC) ? 8'hFF : ~(8'b1 << e.rr);
      e.seg  = ref_glyph(dh_exp);
      e.ft   = ((kn % (8 * RD)) == 0);
      q.push_back(e);
      k <= kn;
    end
  end

  // Monitor: reset values while held, otherwise scoreboard entries
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      q.delete();
      check("reset_rr", int'(rr), 0);
      check("reset_an", int'(an), 8'hFF);
      check("reset_seg", int'(seg), 7'h7F);
      check("reset_dp", int'(dp), 1);
      check("reset_ft", int'(ft), 0);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      check("rr", int'(rr), int'(e.rr));
      check("an", int'(an), int'(e.an));
      check("seg", int'(seg), int'(e.seg));
      check("frame_tick", int'(ft), int'(e.ft));
      check("dp", int'(dp), 1);
      check("an_at_most_one_low", ($countones(~an) <= 1) ? 1 : 0, 1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  // Advance until the edge count hits target modulo m, bounded
  task automatic wait_k(input int m, input int target, input int limit);
    bit hit;
    hit = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      if ((k % m) == target) hit = 1;
      else cycles(1);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_k timeout actual=%0d required=%0d mod %0d", k % m, target, m);
    end
  endtask

  initial begin
    logic [4:0] specials [4] = '{5'd16, 5'd17, 5'd31, 5'd10};

    for (int i = 0; i < 8; i++) codes[i] = 5'(i);

    // Reset held across several edges, then released mid low phase
    cycles(4);
    rst_n = 1'b1;
    $display("reset: released, checks=%0d", checks);

    // Scan order over two frames with digit_holder = rr
    cycles(2 * 8 * RD + 4);
    $display("scan: two frames, checks=%0d", checks);

    // Special codes via override, then every code once
    for (int i = 0; i < 4; i++) begin
      ovr_val = specials[i];
      ovr_en  = 1'b1;
      cycles(3);
    end
    for (int c = 0; c < 32; c++) begin
      ovr_val = 5'(c);
      cycles(2);
    end
    ovr_en = 1'b0;
    $display("codes: specials and all 32 codes, checks=%0d", checks);

    // Anti-ghost: only digit 3 shows an 8 (all segments lit)
    for (int i = 0; i < 8; i++) codes[i] = 5'd16;
    codes[3] = 5'd8;
    cycles(8 * RD + 6);
    $display("antighost: one frame, checks=%0d", checks);

    // Randomized code tables and mid-slot overrides
    repeat (200) begin
      if ($urandom_range(0, 7) == 0) codes[$urandom_range(0, 7)] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) begin
        ovr_en  = 1'($urandom_range(0, 1));
        ovr_val = 5'($urandom_range(0, 31));
      end
      cycles(1);
    end
    ovr_en = 1'b0;
    $display("random: 200 cycles, checks=%0d", checks);

    // Mid-slot reset at rr=5, slot cycle 4
    wait_k(8 * RD, 5 * RD + 4, 200);
    check("pre_reset_rr", int'(rr), 5);
    rst_n = 1'b0;
    #1;
    check("async_reset_rr", int'(rr), 0);
    check("async_reset_an", int'(an), 8'hFF);
    check("async_reset_seg", int'(seg), 7'h7F);
    check("async_reset_ft", int'(ft), 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(3 * RD);
    $display("midslot_reset: restart verified, checks=%0d", checks);

    // Mid-slot code change 3 -> 17 at slot cycle 5
    for (int i = 0; i < 8; i++) codes[i] = 5'd3;
    wait_k(RD, 5, 50);
    check("pre_change_seg", int'(seg), 7'h30);
    ovr_val = 5'd17;
    ovr_en  = 1'b1;
    cycles(1);
    check("post_change_seg", int'(seg), 7'h3F);
    check("post_change_an_lit", ($countones(~an) == 1) ? 1 : 0, 1);
    cycles(3);
    ovr_en = 1'b0;
    cycles(10);
    $display("midslot_change: done, checks=%0d", checks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
